mac_mul_seq_ctrl: RTL and testbench
===================================

// Module: mac_mul_seq_ctrl
// PURPOSE
//  Sequencer that runs full-width integer multiplies on the shared 4-lane x 8-bit MAC multiply block.
//  Accepts A*B requests with valid/ready (cfg: single 8x8, dual 16x16, quad 32x32).
//  Feeds one B byte per step against all A lanes and shift-accumulates each product.
//  Returns the 2N-bit product with valid/ready.
//  Sits between the MAC issue logic and the multiply block; one request in flight.
// PARAMETERS
//  MAC_CONF_WIDTH  2                  cfg width (00 single, 01 dual, 10 quad, 11 illegal)
//  MAC_MIN_WIDTH   8                  lane/byte width
//  MAC_INT_WIDTH   5*MAC_MIN_WIDTH    width of multiply-block result mul_c
// PORTS
//  clk        in   1      clock; all state on rising edge
//  rst        in   1      asynchronous, active-low reset
//  en         in   1      clock enable; low = hold all state, no handshakes
//  req_valid  in   1      request valid
//  req_ready  out  1      request ready (high only in IDLE)
//  req_cfg    in   2      operand config
//  req_a      in   4*MIN  multiplicand; bits above operand width ignored
//  req_b      in   4*MIN  multiplier; bits above operand width ignored
//  rsp_valid  out  1      result valid
//  rsp_ready  in   1      result accepted
//  rsp_p      out  8*MIN  product, zero-extended above 2N bits
//  rsp_err    out  1      request had cfg=11
//  mul_cfg    out  2      to multiply block cfg
//  mul_b2     out  MIN    to multiply block B2
//  mul_a0..3  out  MIN    to multiply block A0..A3 (four ports)
//  mul_c      in   INT    combinational product from multiply block
// BEHAVIOUR
//  Reset (rst=0)
//   - State IDLE; accumulator, captured operands and step counter cleared.
//   - Outputs: req_ready=1, rsp_valid=0, rsp_p=0, rsp_err=0, mul_*=0.
//   - Reset mid-operation abandons the request; no response is produced.
//  Step count S by cfg: single=1, dual=2, quad=4, cfg=11 gives S=0.
//  Accept
//   - Occurs on a rising edge with en & req_valid & req_ready.
//   - Captures cfg, A, B masked to N = 8*S bits.
//   - Clears the accumulator and sets k=0.
//   - Goes to RUN, or to RESP with rsp_err=1 and rsp_p=0 if S=0.
//  RUN, step k (0..S-1), one en-cycle per step
//   - mul_cfg = captured cfg; mul_b2 = B byte k.
//   - single: a2=A[7:0]; a0=a1=a3=0.
//   - dual: a2=A[7:0], a3=A[15:8]; a0=a1=0.
//   - quad: a0..a3 = A bytes 0..3.
//   - At the edge: acc <= acc + (mul_c << 8k), with mul_c zero-extended and the sum mod 2^(8*MIN).
//   - After step S-1, go to RESP.
//  mul_c is sampled the same cycle it is driven, because the multiply block is not pipelined.
//  RESP
//   - rsp_valid=1; rsp_p=acc.
//   - rsp_p, rsp_err and rsp_valid are held stable until en & rsp_ready, then return to IDLE.
//   - A new request is not accepted in the same cycle (req_ready=0 in RESP).
//  Latency: rsp_valid rises S+1 cycles after the accept edge when en=1 throughout.
//  In IDLE and RESP, mul_* are driven 0 so the shared block is quiet.
//  en=0 freezes state, k, acc and all outputs. A step stalled by en=0 is re-executed with identical mul_* values.
//  rsp_ready while rsp_valid=0 is ignored. req_valid outside IDLE is ignored and must not be dropped silently: the requester holds it.
//  Product widths: single 16b, dual 32b, quad 64b; the bits of rsp_p above these are 0.
// TESTING (bench models mul_c as the unsigned product of the driven lanes, per cfg)
//  1. single, req_a=0xDEAD00FF, req_b=0x123400FF
//     -> rsp_p=0x000000000000FE01 at accept+2; upper operand bits masked.
//  2. dual, A=0x1234, B=0xABCD
//     -> mul_b2 = 0xCD then 0xAB; rsp_p=0x0C374FA4 at accept+3.
//  3. quad, A=B=0xFFFFFFFF
//     -> mul_b2 = 0xFF for 4 steps; rsp_p=0xFFFFFFFE00000001 at accept+5; rsp_err=0.
//  4. quad 0x00010000*0x00010000 then rsp_ready=0 for 3 cycles
//     -> rsp_p=0x100000000 held stable, req_ready=0, a second req_valid is not accepted until rsp_ready.
//  5. quad with en=0 for 2 cycles during step 2
//     -> mul_* held, result unchanged, latency accept+7.
//     -> then reset asserted mid-run: all outputs 0/IDLE, next dual request correct.
//  6. cfg=11 -> rsp_valid at accept+1, rsp_err=1, rsp_p=0, mul_* remain 0.

Source files
------------

// File: rtl/mac_mul_seq_ctrl_if.sv
// Request/response and multiply-block bundle for the MAC multiply sequencer.
// The slave side is the sequencer; the master side is its environment.
interface mac_mul_seq_ctrl_if #(
  parameter int MAC_CONF_WIDTH = 2,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH
);
  logic                        req_valid;
  logic                        req_ready;
  logic [MAC_CONF_WIDTH-1:0]   req_cfg;
  logic [4*MAC_MIN_WIDTH-1:0]  req_a;
  logic [4*MAC_MIN_WIDTH-1:0]  req_b;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [8*MAC_MIN_WIDTH-1:0]  rsp_p;
  logic                        rsp_err;
  logic [MAC_CONF_WIDTH-1:0]   mul_cfg;
  logic [MAC_MIN_WIDTH-1:0]    mul_b2;
  logic [MAC_MIN_WIDTH-1:0]    mul_a0;
  logic [MAC_MIN_WIDTH-1:0]    mul_a1;
  logic [MAC_MIN_WIDTH-1:0]    mul_a2;
  logic [MAC_MIN_WIDTH-1:0]    mul_a3;
  logic [MAC_INT_WIDTH-1:0]    mul_c;

  modport master (
    output req_valid, req_cfg, req_a, req_b, rsp_ready, mul_c,
    input  req_ready, rsp_valid, rsp_p, rsp_err,
           mul_cfg, mul_b2, mul_a0, mul_a1, mul_a2, mul_a3
  );

  modport slave (
    input  req_valid, req_cfg, req_a, req_b, rsp_ready, mul_c,
    output req_ready, rsp_valid, rsp_p, rsp_err,
           mul_cfg, mul_b2, mul_a0, mul_a1, mul_a2, mul_a3
  );
endinterface

// File: rtl/mac_mul_seq_ctrl.sv
// Sequences a full-width A*B over the shared 4-lane byte multiplier, one B byte
// per step, shift-accumulating each partial product; one request in flight.
module mac_mul_seq_ctrl #(
  parameter int MAC_CONF_WIDTH = 2,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  mac_mul_seq_ctrl_if.slave    bus
);
  localparam int A_W = 4 * MAC_MIN_WIDTH;
  localparam int P_W = 8 * MAC_MIN_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

  state_t                    r_state, w_next;
  logic [MAC_CONF_WIDTH-1:0] r_cfg;
  logic [A_W-1:0]            r_a, r_b;
  logic [1:0]                r_k;
  logic [P_W-1:0]            r_acc;
  logic                      r_err;
  logic [P_W-1:0]            w_acc_sum;
  logic [1:0]                w_last;

  function automatic logic [2:0] f_steps(input logic [MAC_CONF_WIDTH-1:0] cfg);
    case (cfg)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [A_W-1:0] f_mask(input logic [MAC_CONF_WIDTH-1:0] cfg,
                                             input logic [A_W-1:0] x);
    logic [A_W-1:0] m;
    case (cfg)
      2'b00:   m = A_W'({MAC_MIN_WIDTH{1'b1}});
      2'b01:   m = A_W'({(2*MAC_MIN_WIDTH){1'b1}});
      2'b10:   m = '1;
      default: m = '0;
    endcase
    return x & m;
  endfunction

  assign w_last    = 2'(f_steps(r_cfg) - 3'd1);
  // Partial product for byte k lands at bit 8k; wrap-around above P_W is intended.
  assign w_acc_sum = r_acc + (P_W'(bus.mul_c) << {r_k, 3'b000});

  always_comb begin
    w_next        = r_state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_p     = '0;
    bus.rsp_err   = 1'b0;
    bus.mul_cfg   = '0;
    bus.mul_b2    = '0;
    bus.mul_a0    = '0;
    bus.mul_a1    = '0;
    bus.mul_a2    = '0;
    bus.mul_a3    = '0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (i_en && bus.req_valid)
          w_next = (f_steps(bus.req_cfg) == 3'd0) ? S_RESP : S_RUN;
      end
      S_RUN: begin
        bus.mul_cfg = r_cfg;
        bus.mul_b2  = r_b[{r_k, 3'b000} +: MAC_MIN_WIDTH];
        // Narrow operands sit in the upper lanes of the shared block.
        case (r_cfg)
          2'b00: bus.mul_a2 = r_a[MAC_MIN_WIDTH-1:0];
          2'b01: begin
            bus.mul_a2 = r_a[MAC_MIN_WIDTH-1:0];
            bus.mul_a3 = r_a[2*MAC_MIN_WIDTH-1:MAC_MIN_WIDTH];
          end
          default: begin
            bus.mul_a0 = r_a[MAC_MIN_WIDTH-1:0];
            bus.mul_a1 = r_a[2*MAC_MIN_WIDTH-1:MAC_MIN_WIDTH];
            bus.mul_a2 = r_a[3*MAC_MIN_WIDTH-1:2*MAC_MIN_WIDTH];
            bus.mul_a3 = r_a[4*MAC_MIN_WIDTH-1:3*MAC_MIN_WIDTH];
          end
        endcase
        if (i_en && r_k == w_last) w_next = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_p     = r_acc;
        bus.rsp_err   = r_err;
        if (i_en && bus.rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cfg   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      r_err   <= 1'b0;
    end else if (i_en) begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_cfg <= bus.req_cfg;
            r_a   <= f_mask(bus.req_cfg, bus.req_a);
            r_b   <= f_mask(bus.req_cfg, bus.req_b);
            r_acc <= '0;
            r_k   <= '0;
            r_err <= (f_steps(bus.req_cfg) == 3'd0);
          end
        end
        S_RUN: begin
          r_acc <= w_acc_sum;
          r_k   <= r_k + 2'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_mul_seq_ctrl.sv
// Bench for mac_mul_seq_ctrl: whole-product reference model compared every
// cycle, directed cases with literal expectations, then randomized traffic.
module tb_mac_mul_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  mac_mul_seq_ctrl_if bus();
  mac_mul_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .i_en(en), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiply block: unsigned product of the lanes in use times B2.
  always_comb begin
    case (bus.mul_cfg)
      2'b00:   bus.mul_c = 40'(bus.mul_a2) * 40'(bus.mul_b2);
      2'b01:   bus.mul_c = 40'({bus.mul_a3, bus.mul_a2}) * 40'(bus.mul_b2);
      2'b10:   bus.mul_c = 40'({bus.mul_a3, bus.mul_a2, bus.mul_a1, bus.mul_a0}) * 40'(bus.mul_b2);
      default: bus.mul_c = 40'd0;
    endcase
  end

  function automatic int steps_of(input logic [1:0] c);
    return (c == 2'd0) ? 1 : (c == 2'd1) ? 2 : (c == 2'd2) ? 4 : 0;
  endfunction

  function automatic logic [63:0] opmask(input logic [1:0] c);
    return (64'd1 << (8 * steps_of(c))) - 64'd1;
  endfunction

  function automatic logic [31:0] lanes_of(input logic [1:0] c, input logic [31:0] a);
    case (c)
      2'd0:    return {8'h00, a[7:0], 16'h0000};
      2'd1:    return {a[15:0], 16'h0000};
      2'd2:    return a;
      default: return 32'h0;
    endcase
  endfunction

  // Reference: an outstanding request ages one step per enabled cycle; it is
  // answered once its age reaches the step count, and retired on rsp_ready.
  bit          m_busy = 1'b0;
  int          m_age  = 0;
  int          m_s    = 0;
  logic [1:0]  m_cfg  = '0;
  logic [31:0] m_a    = '0;
  logic [31:0] m_b    = '0;
  logic [63:0] m_prod = '0;
  bit          m_err  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_age  <= 0;
    end else if (en) begin
      if (!m_busy) begin
        if (bus.req_valid) begin
          m_busy <= 1'b1;
          m_age  <= 0;
          m_s    <= steps_of(bus.req_cfg);
          m_cfg  <= bus.req_cfg;
          m_a    <= 32'(64'(bus.req_a) & opmask(bus.req_cfg));
          m_b    <= 32'(64'(bus.req_b) & opmask(bus.req_cfg));
          m_prod <= (64'(bus.req_a) & opmask(bus.req_cfg)) * (64'(bus.req_b) & opmask(bus.req_cfg));
          m_err  <= (steps_of(bus.req_cfg) == 0);
        end
      end else if (m_age < m_s) begin
        m_age <= m_age + 1;
      end else if (bus.rsp_ready) begin
        m_busy <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  bit e_run, e_resp;
  always @(negedge clk) begin
    e_run  = m_busy && (m_age < m_s);
    e_resp = m_busy && (m_age >= m_s);
    chk("req_ready", 64'(bus.req_ready), 64'(!m_busy));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(e_resp));
    chk("rsp_p", bus.rsp_p, e_resp ? m_prod : 64'd0);
    chk("rsp_err", 64'(bus.rsp_err), 64'(e_resp && m_err));
    chk("mul_cfg", 64'(bus.mul_cfg), e_run ? 64'(m_cfg) : 64'd0);
    chk("mul_b2", 64'(bus.mul_b2), e_run ? 64'(8'(m_b >> (8 * m_age))) : 64'd0);
    chk("mul_a", 64'({bus.mul_a3, bus.mul_a2, bus.mul_a1, bus.mul_a0}),
        e_run ? 64'(lanes_of(m_cfg, m_a)) : 64'd0);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                      output int acc_cyc);
    bus.req_valid = 1'b1;
    bus.req_cfg   = c;
    bus.req_a     = a;
    bus.req_b     = b;
    acc_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (en && bus.req_ready) begin
        acc_cyc = cyc;
        step();
        break;
      end
      step();
    end
    bus.req_valid = 1'b0;
    chk("accept_seen", 64'(acc_cyc >= 0), 64'd1);
  endtask

  task automatic wait_rsp(input int acc_cyc, output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) begin
        lat = cyc - acc_cyc;
        break;
      end
      step();
    end
  endtask

  task automatic drain();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  int  ac, ac2, lat, c_rr;
  bit  acc_flag;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_cfg   = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    en = 1'b1;
    repeat (3) step();
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_p", bus.rsp_p, 64'd0);
    rst_n = 1'b1;
    step();

    // single: upper operand bits are ignored
    send(2'd0, 32'hDEAD00FF, 32'h123400FF, ac);
    wait_rsp(ac, lat);
    chk("t1_latency", 64'(lat), 64'd2);
    chk("t1_p", bus.rsp_p, 64'h000000000000FE01);
    drain();

    // dual: B bytes issued low first
    send(2'd1, 32'h00001234, 32'h0000ABCD, ac);
    chk("t2_b2_step0", 64'(bus.mul_b2), 64'hCD);
    step();
    chk("t2_b2_step1", 64'(bus.mul_b2), 64'hAB);
    wait_rsp(ac, lat);
    chk("t2_latency", 64'(lat), 64'd3);
    chk("t2_p", bus.rsp_p, 64'h000000000C374FA4);
    drain();

    // quad all-ones
    send(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, ac);
    wait_rsp(ac, lat);
    chk("t3_latency", 64'(lat), 64'd5);
    chk("t3_p", bus.rsp_p, 64'hFFFFFFFE00000001);
    chk("t3_err", 64'(bus.rsp_err), 64'd0);
    drain();

    // response back-pressure with a competing request held
    send(2'd2, 32'h00010000, 32'h00010000, ac);
    wait_rsp(ac, lat);
    bus.req_valid = 1'b1;
    bus.req_cfg   = 2'd2;
    bus.req_a     = 32'd2;
    bus.req_b     = 32'd3;
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_p", bus.rsp_p, 64'h0000000100000000);
      chk("t4_req_ready", 64'(bus.req_ready), 64'd0);
      step();
    end
    c_rr = cyc;
    bus.rsp_ready = 1'b1;
    send(2'd2, 32'd2, 32'd3, ac2);
    bus.rsp_ready = 1'b0;
    chk("t4_no_early_accept", 64'(ac2 - c_rr), 64'd1);
    wait_rsp(ac2, lat);
    chk("t4_second_p", bus.rsp_p, 64'd6);
    drain();

    // quad with a two-cycle enable stall in step 2
    send(2'd2, 32'h01020304, 32'h05060708, ac);
    step();
    step();
    en = 1'b0;
    step();
    chk("t5_stall_b2", 64'(bus.mul_b2), 64'h06);
    step();
    chk("t5_stall_a", 64'({bus.mul_a3, bus.mul_a2, bus.mul_a1, bus.mul_a0}), 64'h01020304);
    en = 1'b1;
    wait_rsp(ac, lat);
    chk("t5_latency", 64'(lat), 64'd7);
    chk("t5_p", bus.rsp_p, 64'h01020304 * 64'h05060708);
    drain();

    // reset abandons an in-flight request
    send(2'd1, 32'h0000BEEF, 32'h00001234, ac);
    step();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("t5_rst_mul_b2", 64'(bus.mul_b2), 64'd0);
    chk("t5_rst_mul_cfg", 64'(bus.mul_cfg), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t5_rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
    send(2'd1, 32'h0000BEEF, 32'h00001234, ac);
    wait_rsp(ac, lat);
    chk("t5_after_rst_lat", 64'(lat), 64'd3);
    chk("t5_after_rst_p", bus.rsp_p, 64'h000000000D93968C);
    drain();

    // illegal config
    send(2'd3, 32'h12345678, 32'h9ABCDEF0, ac);
    chk("t6_mul_cfg", 64'(bus.mul_cfg), 64'd0);
    wait_rsp(ac, lat);
    chk("t6_latency", 64'(lat), 64'd1);
    chk("t6_err", 64'(bus.rsp_err), 64'd1);
    chk("t6_p", bus.rsp_p, 64'd0);
    drain();

    // randomized traffic; requester holds req_valid until accepted
    acc_flag = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (acc_flag) bus.req_valid = 1'b0;
      if (!bus.req_valid && $urandom_range(0, 2) == 0) begin
        bus.req_valid = 1'b1;
        bus.req_cfg   = 2'($urandom_range(0, 3));
        bus.req_a     = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
        bus.req_b     = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      end
      en = ($urandom_range(0, 4) != 0);
      bus.rsp_ready = 1'($urandom_range(0, 1));
      acc_flag = en && bus.req_valid && bus.req_ready;
      step();
    end
    bus.req_valid = 1'b0;
    en = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
